// File: rtl/pe_pkg.sv
// Shared types and helpers for the systolic processing elements.
// Widths, FSM states and saturation bounds live here.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_MAX_LEN    = 256;
  localparam int SAT_W          = 64;

  function automatic int min_acc_width(
    input int dw,
    input int max_len
  );
    return 2 * dw + $clog2(max_len);
  endfunction

  // Bounds are returned in SAT_W bits; callers truncate to ACC_WIDTH.
  function automatic logic [SAT_W-1:0] sat_max(
    input int aw,
    input bit sgn
  );
    logic [SAT_W-1:0] m;
    m = '1;
    return sgn ? (m >> (SAT_W + 1 - aw))
               : (m >> (SAT_W - aw));
  endfunction

  function automatic logic [SAT_W-1:0] sat_min(
    input int aw,
    input bit sgn
  );
    return sgn ? (SAT_W'(1) << (aw - 1)) : '0;
  endfunction

endpackage

// File: rtl/pe_os_acc_mac.sv
// Combinational multiply-accumulate with optional clamping.
// Shared between output- and weight-stationary PEs.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic                  first,
  output logic [ACC_WIDTH-1:0]  sum
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam bit SG = (SIGNED != 0);
  localparam logic [AW-1:0] SMAX = AW'(sat_max(AW, SG));
  localparam logic [AW-1:0] SMIN = AW'(sat_min(AW, SG));

  logic [AW-1:0] a_x;
  logic [AW-1:0] b_x;
  logic [AW-1:0] prod;
  logic [AW-1:0] base;
  logic [AW:0]   raw;

  // Product fits in 2*DW <= AW, so an AW-wide multiply is exact.
  assign a_x  = {{(AW-DW){SG & a[DW-1]}}, a};
  assign b_x  = {{(AW-DW){SG & b[DW-1]}}, b};
  assign prod = a_x * b_x;
  assign base = first ? '0 : acc;
  assign raw  = {SG & base[AW-1], base}
              + {SG & prod[AW-1], prod};

  always_comb begin
    sum = raw[AW-1:0];
    if (SATURATE != 0) begin
      if (SG) begin
        if (raw[AW] != raw[AW-1])
          sum = raw[AW] ? SMIN : SMAX;
      end else if (raw[AW]) begin
        sum = SMAX;
      end
    end
  end

endmodule

// File: rtl/pe_os_acc.sv
// Output-stationary PE: operand forwarding, dot-product FSM
// and a per-column psum shift chain for unloading results.
module pe_os_acc
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] top_in,
  input  logic                  top_valid,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic                  left_valid,
  input  logic                  left_first,
  input  logic                  left_last,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  right_valid,
  output logic                  right_first,
  output logic                  right_last,
  output logic [DATA_WIDTH-1:0] bottom_out,
  output logic                  bottom_valid,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  psum_in_valid,
  input  logic                  drain_load,
  input  logic                  drain_shift,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_out_valid,
  output logic                  result_ready,
  output logic                  overrun
);

  state_t               state_q;
  state_t               state_d;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] mac_sum;
  logic                 fire;
  logic                 acc_en;
  logic                 ovr_d;

  assign fire = left_valid & top_valid;

  pe_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SIGNED     (SIGNED),
    .SATURATE   (SATURATE)
  ) u_mac (
    .a     (left_in),
    .b     (top_in),
    .acc   (acc_q),
    .first (left_first),
    .sum   (mac_sum)
  );

  always_comb begin
    state_d = state_q;
    acc_en  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          acc_en = 1'b1;
          if (left_first)
            state_d = left_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (fire) begin
          acc_en = 1'b1;
          if (left_last)
            state_d = HOLD;
        end
      end
      HOLD: begin
        // A new dot product overwrites the held result unless
        // it is being copied into the chain this same cycle.
        if (fire & left_first) begin
          acc_en  = 1'b1;
          ovr_d   = ~drain_load;
          state_d = left_last ? HOLD : ACC;
        end else if (drain_load) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      overrun <= ovr_d;
      if (acc_en)
        acc_q <= mac_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      right_out    <= '0;
      right_valid  <= 1'b0;
      right_first  <= 1'b0;
      right_last   <= 1'b0;
      bottom_out   <= '0;
      bottom_valid <= 1'b0;
    end else begin
      right_out    <= left_in;
      right_valid  <= left_valid;
      right_first  <= left_first;
      right_last   <= left_last;
      bottom_out   <= top_in;
      bottom_valid <= top_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum_out       <= '0;
      psum_out_valid <= 1'b0;
    end else if (drain_load) begin
      psum_out       <= acc_q;
      psum_out_valid <= (state_q == HOLD);
    end else if (drain_shift) begin
      psum_out       <= psum_in;
      psum_out_valid <= psum_in_valid;
    end
  end

  assign result_ready = (state_q == HOLD);

endmodule

// File: tb/tb_pe_os_acc.sv
// Directed self-checking bench for pe_os_acc: single PEs in
// three configurations plus a 4-deep psum column.
module tb_pe_os_acc;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  top_in = '0, left_in = '0;
  logic        top_valid = 0, left_valid = 0;
  logic        left_first = 0, left_last = 0;
  logic        drain_load = 0, drain_shift = 0;

  logic [7:0]  right_out, bottom_out;
  logic        right_valid, right_first, right_last, bottom_valid;
  logic [23:0] psum_out;
  logic        psum_out_valid, result_ready, overrun;

  logic [15:0] us_psum, uw_psum;
  logic        us_pv, uw_pv;
  logic [7:0]  us_ro, us_bo, uw_ro, uw_bo;
  logic [5:0]  us_misc, uw_misc;

  pe_os_acc #(.DATA_WIDTH(8), .ACC_WIDTH(24), .SIGNED(1), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .top_in(top_in), .top_valid(top_valid),
    .left_in(left_in), .left_valid(left_valid), .left_first(left_first),
    .left_last(left_last), .right_out(right_out), .right_valid(right_valid),
    .right_first(right_first), .right_last(right_last),
    .bottom_out(bottom_out), .bottom_valid(bottom_valid),
    .psum_in(24'd0), .psum_in_valid(1'b0), .drain_load(drain_load),
    .drain_shift(drain_shift), .psum_out(psum_out),
    .psum_out_valid(psum_out_valid), .result_ready(result_ready),
    .overrun(overrun)
  );

  pe_os_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1)) u_us (
    .clk(clk), .rst(rst), .top_in(top_in), .top_valid(top_valid),
    .left_in(left_in), .left_valid(left_valid), .left_first(left_first),
    .left_last(left_last), .right_out(us_ro), .right_valid(us_misc[0]),
    .right_first(us_misc[1]), .right_last(us_misc[2]),
    .bottom_out(us_bo), .bottom_valid(us_misc[3]),
    .psum_in(16'd0), .psum_in_valid(1'b0), .drain_load(drain_load),
    .drain_shift(drain_shift), .psum_out(us_psum),
    .psum_out_valid(us_pv), .result_ready(us_misc[4]),
    .overrun(us_misc[5])
  );

  pe_os_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0)) u_uw (
    .clk(clk), .rst(rst), .top_in(top_in), .top_valid(top_valid),
    .left_in(left_in), .left_valid(left_valid), .left_first(left_first),
    .left_last(left_last), .right_out(uw_ro), .right_valid(uw_misc[0]),
    .right_first(uw_misc[1]), .right_last(uw_misc[2]),
    .bottom_out(uw_bo), .bottom_valid(uw_misc[3]),
    .psum_in(16'd0), .psum_in_valid(1'b0), .drain_load(drain_load),
    .drain_shift(drain_shift), .psum_out(uw_psum),
    .psum_out_valid(uw_pv), .result_ready(uw_misc[4]),
    .overrun(uw_misc[5])
  );

  logic [7:0]  col_top [4];
  logic        col_tv = 0, col_lv = 0, col_lf = 0, col_ll = 0;
  logic [23:0] col_psum [5];
  logic        col_pv [5];
  logic [7:0]  col_ro [4], col_bo [4];
  logic [5:0]  col_misc [4];

  assign col_psum[0] = '0;
  assign col_pv[0]   = 1'b0;

  for (genvar g = 0; g < 4; g++) begin : g_col
    pe_os_acc u_pe (
      .clk(clk), .rst(rst), .top_in(col_top[g]), .top_valid(col_tv),
      .left_in(8'd1), .left_valid(col_lv), .left_first(col_lf),
      .left_last(col_ll), .right_out(col_ro[g]),
      .right_valid(col_misc[g][0]), .right_first(col_misc[g][1]),
      .right_last(col_misc[g][2]), .bottom_out(col_bo[g]),
      .bottom_valid(col_misc[g][3]), .psum_in(col_psum[g]),
      .psum_in_valid(col_pv[g]), .drain_load(drain_load),
      .drain_shift(drain_shift), .psum_out(col_psum[g+1]),
      .psum_out_valid(col_pv[g+1]), .result_ready(col_misc[g][4]),
      .overrun(col_misc[g][5])
    );
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic lv, input logic tv,
                       input logic f, input logic l);
    left_in = a; top_in = b; left_valid = lv; top_valid = tv;
    left_first = f; left_last = l;
    @(negedge clk);
  endtask

  task automatic drain(input logic ld, input logic sh);
    drain_load = ld; drain_shift = sh;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain_load = 0; drain_shift = 0;
  endtask

  task automatic do_reset();
    drain_load = 0; drain_shift = 0;
    col_tv = 0; col_lv = 0; col_lf = 0; col_ll = 0;
    for (int i = 0; i < 4; i++) col_top[i] = '0;
    left_in = 0; top_in = 0; left_valid = 0; top_valid = 0;
    left_first = 0; left_last = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({result_ready, overrun, psum_out_valid, right_valid} !== 4'b0 ||
        psum_out !== 24'd0) begin
      errors++;
      $display("FAIL reset_state got rr=%b ov=%b pv=%b rv=%b psum=%0d want 0",
               result_ready, overrun, psum_out_valid, right_valid, psum_out);
    end
    drive(8'd37, 8'd1, 1, 1, 1, 0);
    drain_load = 1;
    drive(8'd5, 8'd0, 1, 0, 0, 0);
    drain_load = 0;
    checks++;
    if (psum_out !== 24'd37 || psum_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_in_acc got %0d/%b want 37/0",
               psum_out, psum_out_valid);
    end
    rst = 1;
    #1;
    checks++;
    if (psum_out !== 24'd0 || right_out !== 8'd0 ||
        right_valid !== 1'b0 || result_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got psum=%0d ro=%0d rv=%b rr=%b want 0",
               psum_out, right_out, right_valid, result_ready);
    end
    @(negedge clk);
    rst = 0;
    drive(8'd2, 8'd3, 1, 1, 0, 1);
    checks++;
    if (result_ready !== 1'b0) begin
      errors++;
      $display("FAIL no_first_no_ready got %b want 0", result_ready);
    end
    drain(1, 0);
    checks++;
    if (psum_out !== 24'd6 || psum_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL acc_cleared got %0d/%b want 6/0",
               psum_out, psum_out_valid);
    end
  endtask

  task automatic test_signed();
    do_reset();
    drive(8'hFD, 8'd4, 1, 1, 1, 0);
    drive(8'd5, 8'd6, 1, 1, 0, 0);
    checks++;
    if (result_ready !== 1'b0) begin
      errors++;
      $display("FAIL signed_early_ready got %b want 0", result_ready);
    end
    drive(8'h80, 8'h80, 1, 1, 0, 1);
    checks++;
    if (result_ready !== 1'b1) begin
      errors++;
      $display("FAIL signed_ready got %b want 1", result_ready);
    end
    drain(1, 0);
    checks++;
    if (psum_out !== 24'd16402 || psum_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL signed_psum got %0d/%b want 16402/1",
               psum_out, psum_out_valid);
    end
    checks++;
    if (result_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_clear got %b want 0", result_ready);
    end
  endtask

  task automatic test_unsigned();
    do_reset();
    drive(8'd255, 8'd255, 1, 1, 1, 0);
    drive(8'd255, 8'd255, 1, 1, 0, 1);
    drain(1, 0);
    checks++;
    if (us_psum !== 16'd65535 || us_pv !== 1'b1) begin
      errors++;
      $display("FAIL unsigned_sat got %0d/%b want 65535/1", us_psum, us_pv);
    end
    checks++;
    if (uw_psum !== 16'd64514 || uw_pv !== 1'b1) begin
      errors++;
      $display("FAIL unsigned_wrap got %0d/%b want 64514/1", uw_psum, uw_pv);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    drive(8'd7, 8'd9, 1, 1, 1, 1);
    checks++;
    if (result_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b want 1", result_ready);
    end
    drain(1, 0);
    checks++;
    if (psum_out !== 24'd63 || psum_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_psum got %0d/%b want 63/1",
               psum_out, psum_out_valid);
    end
    drive(8'd2, 8'd2, 1, 1, 1, 1);
    checks++;
    if (overrun !== 1'b0 || result_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_again got ov=%b rr=%b want 0/1",
               overrun, result_ready);
    end
    drive(8'd2, 8'd3, 1, 1, 1, 0);
    checks++;
    if (overrun !== 1'b1 || result_ready !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pulse got ov=%b rr=%b want 1/0",
               overrun, result_ready);
    end
    drive(8'd4, 8'd5, 1, 1, 0, 1);
    checks++;
    if (overrun !== 1'b0 || result_ready !== 1'b1) begin
      errors++;
      $display("FAIL overrun_one_cycle got ov=%b rr=%b want 0/1",
               overrun, result_ready);
    end
    drain(1, 0);
    checks++;
    if (psum_out !== 24'd26 || psum_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_overrun got %0d/%b want 26/1",
               psum_out, psum_out_valid);
    end
  endtask

  task automatic test_column();
    logic [23:0] exp_seq [4];
    exp_seq[0] = 24'd40; exp_seq[1] = 24'd30;
    exp_seq[2] = 24'd20; exp_seq[3] = 24'd10;
    do_reset();
    col_top[0] = 8'd10; col_top[1] = 8'd20;
    col_top[2] = 8'd30; col_top[3] = 8'd40;
    col_tv = 1; col_lv = 1; col_lf = 1; col_ll = 1;
    @(negedge clk);
    col_tv = 0; col_lv = 0; col_lf = 0; col_ll = 0;
    for (int i = 0; i < 4; i++) begin
      drain(i == 0, i != 0);
      checks++;
      if (col_psum[4] !== exp_seq[i] || col_pv[4] !== 1'b1) begin
        errors++;
        $display("FAIL column_%0d got %0d/%b want %0d/1",
                 i, col_psum[4], col_pv[4], exp_seq[i]);
      end
    end
    col_top[0] = 8'd1; col_top[1] = 8'd2;
    col_top[2] = 8'd3; col_top[3] = 8'd4;
    col_tv = 1; col_lv = 1; col_lf = 1; col_ll = 1;
    @(negedge clk);
    col_tv = 0; col_lv = 0; col_lf = 0; col_ll = 0;
    drain(1, 1);
    checks++;
    if (col_psum[4] !== 24'd4 || col_pv[4] !== 1'b1) begin
      errors++;
      $display("FAIL load_wins got %0d/%b want 4/1", col_psum[4], col_pv[4]);
    end
    drain(0, 0);
    checks++;
    if (col_psum[4] !== 24'd4 || col_pv[4] !== 1'b1) begin
      errors++;
      $display("FAIL psum_hold got %0d/%b want 4/1", col_psum[4], col_pv[4]);
    end
  endtask

  task automatic test_forwarding();
    logic [7:0] a, b;
    logic lv, tv, f, l;
    do_reset();
    drive(8'd3, 8'd3, 1, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      lv = 1'($urandom);
      f  = 1'($urandom);
      l  = 1'($urandom);
      tv = (i < 8) ? 1'b0 : 1'($urandom);
      // Second half may fire; keep the accumulator untouched by
      // disabling left_valid whenever top_valid is set.
      if (tv) lv = 1'b0;
      drive(a, b, lv, tv, f, l);
      checks++;
      if (right_out !== a || right_valid !== lv || right_first !== f ||
          right_last !== l || bottom_out !== b || bottom_valid !== tv) begin
        errors++;
        $display("FAIL fwd_%0d got %h%b%b%b/%h%b want %h%b%b%b/%h%b", i,
                 right_out, right_valid, right_first, right_last,
                 bottom_out, bottom_valid, a, lv, f, l, b, tv);
      end
    end
    drive(8'd1, 8'd1, 1, 1, 0, 1);
    drain(1, 0);
    checks++;
    if (psum_out !== 24'd10 || psum_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL lone_valid_acc got %0d/%b want 10/1",
               psum_out, psum_out_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) col_top[i] = '0;
    @(negedge clk);
    test_reset();
    test_signed();
    test_unsigned();
    test_overrun();
    test_column();
    test_forwarding();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
